// File: rtl/serial_pe_pkg.sv
// serial_pe_pkg -- shared constants and types for the serial MAC processing element.
//   DEF_DATA_W / DEF_ACC_W : default operand and accumulator widths
//   CTL_FIRST / CTL_LAST   : bit positions inside the 2-bit ctl field
//   prod_t / acc_t         : full-precision product and accumulator types at default widths
package serial_pe_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 32;

    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;

    typedef logic signed [2*DEF_DATA_W-1:0] prod_t;
    typedef logic signed [DEF_ACC_W-1:0]    acc_t;
    typedef logic [1:0]                     ctl_t;

endpackage

// File: rtl/serial_pe_mac.sv
// serial_pe_mac -- signed multiplier feeding a gated accumulator.
// Optional feature: define SERIAL_PE_MUL_PIPE_EN to register the product together
// with vld_i and ctl, giving one extra cycle of latency at the same throughput.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   neuron, weight  : signed operands
//   ctl             : {last, first} element flags
//   vld_i           : operands/ctl valid
//   sum             : accumulator value including the current element (combinational)
//   last            : current element closes a vector; sum is the final dot product
module serial_pe_mac
    import serial_pe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] neuron,
    input  logic signed [DATA_W-1:0] weight,
    input  logic [1:0]               ctl,
    input  logic                     vld_i,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     last
);

    generate
        if (ACC_W < 2*DATA_W) begin : g_width_check
            $error("serial_pe_mac: ACC_W must be at least 2*DATA_W");
        end
    endgenerate

    logic signed [2*DATA_W-1:0] prod_comb;
    logic signed [2*DATA_W-1:0] prod_stage;
    logic                       vld_stage;
    logic [1:0]                 ctl_stage;

    // Widen both operands first so the multiply is evaluated at full precision.
    assign prod_comb = (2*DATA_W)'(neuron) * (2*DATA_W)'(weight);

`ifdef SERIAL_PE_MUL_PIPE_EN
    logic signed [2*DATA_W-1:0] prod_reg;
    logic                       vld_reg;
    logic [1:0]                 ctl_reg;

    // Product and its qualifiers move together so the accumulator sees a
    // consistent element one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg <= '0;
            vld_reg  <= 1'b0;
            ctl_reg  <= '0;
        end else begin
            prod_reg <= prod_comb;
            vld_reg  <= vld_i;
            ctl_reg  <= ctl;
        end
    end

    assign prod_stage = prod_reg;
    assign vld_stage  = vld_reg;
    assign ctl_stage  = ctl_reg;
`else
    assign prod_stage = prod_comb;
    assign vld_stage  = vld_i;
    assign ctl_stage  = ctl;
`endif

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] acc_reg;

    // Signed size cast sign-extends the product into the accumulator width.
    assign prod_ext = ACC_W'(prod_stage);
    // A first element discards whatever the previous vector left behind.
    assign acc_base = ctl_stage[CTL_FIRST] ? '0 : acc_reg;
    assign acc_next = acc_base + prod_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (vld_stage) begin
            acc_reg <= acc_next;
        end
    end

    assign sum  = acc_next;
    assign last = vld_stage & ctl_stage[CTL_LAST];

endmodule

// File: rtl/serial_pe.sv
// serial_pe -- serial multiply-accumulate processing element (top level).
// Optional feature: define SERIAL_PE_MUL_PIPE_EN for a registered multiplier
// (latency 2 instead of 1, same one-element-per-cycle throughput).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   neuron, weight  : signed DATA_W operands
//   ctl             : bit0 first element (restart), bit1 last element (emit)
//   vld_i           : operands and ctl valid this cycle
//   result          : last completed dot product, held between completions
//   vld_o           : one-cycle pulse marking a new result
module serial_pe
    import serial_pe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] neuron,
    input  logic signed [DATA_W-1:0] weight,
    input  logic [1:0]               ctl,
    input  logic                     vld_i,
    output logic [ACC_W-1:0]         result,
    output logic                     vld_o
);

    logic signed [ACC_W-1:0] mac_sum;
    logic                    mac_last;
    logic [ACC_W-1:0]        result_reg;
    logic                    vld_o_reg;

    serial_pe_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .neuron (neuron),
        .weight (weight),
        .ctl    (ctl),
        .vld_i  (vld_i),
        .sum    (mac_sum),
        .last   (mac_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
            vld_o_reg  <= 1'b0;
        end else begin
            vld_o_reg <= mac_last;
            if (mac_last) begin
                result_reg <= mac_sum;
            end
        end
    end

    assign result = result_reg;
    assign vld_o  = vld_o_reg;

endmodule

// File: tb/tb_serial_pe.sv
// tb_serial_pe -- directed, table-driven bench for serial_pe.
module tb_serial_pe;

`ifdef SERIAL_PE_MUL_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] neuron;
    logic signed [15:0] weight;
    logic [1:0]         ctl;
    logic               vld_i;
    logic [31:0]        result;
    logic               vld_o;

    serial_pe dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .neuron (neuron),
        .weight (weight),
        .ctl    (ctl),
        .vld_i  (vld_i),
        .result (result),
        .vld_o  (vld_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] neuron;
        logic [15:0] weight;
        logic [1:0]  ctl;
        logic        vld;
        logic        exp_vld;
        logic [31:0] exp_result;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] held = 32'h0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected result is the value held at the output once this row has drained.
    task automatic add(input int n, input int w, input logic [1:0] c, input logic v,
                       input logic ev, input logic [31:0] er);
        vec_t r;
        if (ev) held = er;
        r.neuron     = 16'(n);
        r.weight     = 16'(w);
        r.ctl        = c;
        r.vld        = v;
        r.exp_vld    = ev;
        r.exp_result = held;
        tbl.push_back(r);
    endtask

    task automatic apply(input logic [15:0] n, input logic [15:0] w,
                         input logic [1:0] c, input logic v);
        neuron = n;
        weight = w;
        ctl    = c;
        vld_i  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input string name, input logic [31:0] exp);
        int waited = 0;
        while (!vld_o && waited < 4) begin
            apply(16'h0, 16'h0, 2'b00, 1'b0);
            waited++;
        end
        check({name, "_vld"}, {31'b0, vld_o}, 32'h1);
        check({name, "_latency"}, 32'(waited + 1), 32'(LAT));
        check({name, "_result"}, result, exp);
        $display("%s: result=%h cycles=%0d", name, result, waited + 1);
        apply(16'h0, 16'h0, 2'b00, 1'b0);
        check({name, "_pulse_width"}, {31'b0, vld_o}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        neuron = '0;
        weight = '0;
        ctl    = '0;
        vld_i  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 32'h0);
        check("reset_vld_o", {31'b0, vld_o}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(16'h0, 16'h0, 2'b00, 1'b0);
            check("idle_vld_o", {31'b0, vld_o}, 32'h0);
        end

        // 32 x (2*3) = 192
        for (int i = 0; i < 32; i++)
            add(2, 3, {i == 31, i == 0}, 1'b1, i == 31, 32'h0000_00C0);
        // Signed single-element vectors
        add(-1, 4, 2'b11, 1'b1, 1'b1, 32'hFFFF_FFFC);
        add(32'h8000, 32'h8000, 2'b11, 1'b1, 1'b1, 32'h4000_0000);
        // 35 - 6 + 100 - 1 = 128, with a 3-cycle gap carrying junk ctl
        add(5, 7, 2'b01, 1'b1, 1'b0, 32'h0);
        add(-3, 2, 2'b00, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)
            add(32'h1234, 32'h7777, 2'b11, 1'b0, 1'b0, 32'h0);
        add(10, 10, 2'b00, 1'b1, 1'b0, 32'h0);
        add(1, -1, 2'b10, 1'b1, 1'b1, 32'h0000_0080);
        // Same vector without gaps, starting right after the previous last
        add(5, 7, 2'b01, 1'b1, 1'b0, 32'h0);
        add(-3, 2, 2'b00, 1'b1, 1'b0, 32'h0);
        add(10, 10, 2'b00, 1'b1, 1'b0, 32'h0);
        add(1, -1, 2'b10, 1'b1, 1'b1, 32'h0000_0080);
        // Back-to-back independent vector: 20000 - 200 = 19800
        add(100, 200, 2'b01, 1'b1, 1'b0, 32'h0);
        add(-50, 4, 2'b10, 1'b1, 1'b1, 32'h0000_4D58);
        // ctl while vld_i=0 is ignored: 9 + 16 = 25
        add(3, 3, 2'b01, 1'b1, 1'b0, 32'h0);
        add(9, 9, 2'b01, 1'b0, 1'b0, 32'h0);
        add(9, 9, 2'b10, 1'b0, 1'b0, 32'h0);
        add(4, 4, 2'b10, 1'b1, 1'b1, 32'h0000_0019);
        // Wrap: 4 x 0x3FFF0001 mod 2^32
        add(32'h7FFF, 32'h7FFF, 2'b01, 1'b1, 1'b0, 32'h0);
        add(32'h7FFF, 32'h7FFF, 2'b00, 1'b1, 1'b0, 32'h0);
        add(32'h7FFF, 32'h7FFF, 2'b00, 1'b1, 1'b0, 32'h0);
        add(32'h7FFF, 32'h7FFF, 2'b10, 1'b1, 1'b1, 32'hFFFC_0004);
        // Last without first continues the running sum: +1 +4
        add(1, 1, 2'b00, 1'b1, 1'b0, 32'h0);
        add(2, 2, 2'b10, 1'b1, 1'b1, 32'hFFFC_0009);

        for (int k = 0; k < tbl.size() + LAT - 1; k++) begin
            int j;
            if (k < tbl.size())
                apply(tbl[k].neuron, tbl[k].weight, tbl[k].ctl, tbl[k].vld);
            else
                apply(16'h0, 16'h0, 2'b00, 1'b0);
            j = k - (LAT - 1);
            if (j >= 0) begin
                check($sformatf("row%0d_vld_o", j), {31'b0, vld_o}, {31'b0, tbl[j].exp_vld});
                check($sformatf("row%0d_result", j), result, tbl[j].exp_result);
                if (tbl[j].exp_vld)
                    $display("row %0d: result=%h", j, result);
            end
        end

        // Reset mid-vector: 10 elements of 5*5, then asynchronous reset
        for (int i = 0; i < 10; i++)
            apply(16'd5, 16'd5, {1'b0, i == 0}, 1'b1);
        rst_n = 1'b0;
        #2;
        check("async_rst_result", result, 32'h0);
        check("async_rst_vld_o", {31'b0, vld_o}, 32'h0);
        vld_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // New vector omitting first: must start from a cleared accumulator
        apply(16'd1, 16'd1, 2'b00, 1'b1);
        apply(16'd1, 16'd1, 2'b10, 1'b1);
        expect_pulse("rst_new_vec", 32'h0000_0002);

        // Single element again through the hand sequence path
        apply(16'hFFFF, 16'h0004, 2'b11, 1'b1);
        expect_pulse("single_neg", 32'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
